rgb_row_assembler: RTL and testbench

- Upstream stage of the binary threshold filter.
- Accepts a raster stream of 24-bit RGB pixels, one per cycle, under a valid/ready handshake.
- Packs each group of COLS pixels into one wide row word, the same layout the threshold filter takes on row_in.
- Hands rows downstream under a row-level valid/ready handshake. Counts rows per frame and flags the last row.

---
 rtl/rgb_row_assembler.sv | 121 ++++++++++++
 tb/tb_rgb_row_assembler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_row_assembler.sv
// Packs COLS RGB pixels into one row word; row_valid rises on the edge that takes a row's last pixel.
// Backpressure: a held row_out plus a full pack buffer drops pix_ready until row_out is accepted.
module rgb_row_assembler #(
    parameter int COLS  = 256,
    parameter int ROWS  = 256,
    parameter int WIDTH = 8
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic                                   start,
    input  logic [3*WIDTH-1:0]                     pix_in,
    input  logic                                   pix_valid,
    output logic                                   pix_ready,
    output logic [COLS*3*WIDTH-1:0]                row_out,
    output logic                                   row_valid,
    input  logic                                   row_ready,
    output logic                                   row_last,
    output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] row_idx,
    output logic                                   frame_done
);

    localparam int PW = 3 * WIDTH;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]           state;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [COLS*PW-1:0]   pack;
    logic [COLS*PW-1:0]   pack_nxt;

    logic pix_xfer;
    logic row_xfer;
    logic row_done;
    logic out_free;
    logic last_row;

    assign pix_ready = (state == S_FILL);
    assign pix_xfer  = pix_valid && pix_ready;
    assign row_xfer  = row_valid && row_ready;
    assign row_done  = pix_xfer && (col == CW'(COLS - 1));
    assign out_free  = !row_valid || row_ready;
    assign last_row  = (row == RW'(ROWS - 1));

    // Pack buffer including the pixel arriving now, so a completed row can go out on the same edge.
    always_comb begin
        pack_nxt = pack;
        pack_nxt[int'(col)*PW +: PW] = pix_in;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= S_IDLE;
            col        <= '0;
            row        <= '0;
            pack       <= '0;
            row_out    <= '0;
            row_valid  <= 1'b0;
            row_last   <= 1'b0;
            row_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Default drop on acceptance; a load below on the same edge keeps it high.
            if (row_xfer)
                row_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FILL;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                S_FILL: begin
                    if (pix_xfer) begin
                        pack <= pack_nxt;
                        if (row_done) begin
                            col <= '0;
                            if (out_free) begin
                                row_out   <= pack_nxt;
                                row_valid <= 1'b1;
                                row_idx   <= row;
                                row_last  <= last_row;
                                row       <= last_row ? '0 : row + 1'b1;
                                state     <= last_row ? S_DRAIN : S_FILL;
                            end else begin
                                state <= S_STALL;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_STALL: begin
                    if (row_xfer) begin
                        row_out   <= pack;
                        row_valid <= 1'b1;
                        row_idx   <= row;
                        row_last  <= last_row;
                        row       <= last_row ? '0 : row + 1'b1;
                        state     <= last_row ? S_DRAIN : S_FILL;
                    end
                end
                default: begin
                    if (row_xfer) begin
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_row_assembler.sv
// Directed cycle table on a 4x2 instance, then a random-stall soak on a default 256x256 instance.
module tb_rgb_row_assembler;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Small instance: COLS=4, ROWS=2
    logic         s_rst = 1'b0, s_start = 1'b0, s_pv = 1'b0, s_rr = 1'b0;
    logic [23:0]  s_pix = '0;
    logic         s_pr, s_rv, s_rl, s_fd;
    logic [95:0]  s_ro;
    logic [0:0]   s_ri;

    rgb_row_assembler #(.COLS(4), .ROWS(2), .WIDTH(8)) dut_s (
        .CLK(CLK), .RST(s_rst), .start(s_start), .pix_in(s_pix), .pix_valid(s_pv),
        .pix_ready(s_pr), .row_out(s_ro), .row_valid(s_rv), .row_ready(s_rr),
        .row_last(s_rl), .row_idx(s_ri), .frame_done(s_fd));

    // Default instance: 256x256
    logic          d_rst = 1'b0, d_start = 1'b0, d_pv = 1'b0, d_rr = 1'b0;
    logic [23:0]   d_pix = '0;
    logic          d_pr, d_rv, d_rl, d_fd;
    logic [6143:0] d_ro;
    logic [7:0]    d_ri;

    rgb_row_assembler dut_d (
        .CLK(CLK), .RST(d_rst), .start(d_start), .pix_in(d_pix), .pix_valid(d_pv),
        .pix_ready(d_pr), .row_out(d_ro), .row_valid(d_rv), .row_ready(d_rr),
        .row_last(d_rl), .row_idx(d_ri), .frame_done(d_fd));

    typedef struct {
        logic        rst, start, pv;
        logic [23:0] pix;
        logic        rr;
        logic        e_pr, e_rv, cr, e_ri, e_rl, e_fd;
        logic [95:0] e_ro;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic st, input logic pv, input logic [23:0] px,
                       input logic rr, input logic epr, input logic erv, input logic cr,
                       input logic eri, input logic erl, input logic efd, input logic [95:0] ero);
        vec_t v;
        v.rst = rst; v.start = st; v.pv = pv; v.pix = px; v.rr = rr;
        v.e_pr = epr; v.e_rv = erv; v.cr = cr; v.e_ri = eri; v.e_rl = erl; v.e_fd = efd; v.e_ro = ero;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [23:0] gen(input int idx);
        logic [15:0] u;
        u = idx[15:0];
        return {u[7:0] ^ u[15:8] ^ 8'h5A, u[15:8], u[7:0]};
    endfunction

    localparam logic [95:0] R0 = 96'h0A0B0C_070809_040506_010203;
    localparam logic [95:0] R1 = 96'h444444_333333_222222_111111;
    localparam logic [95:0] R2 = 96'h000004_000003_000002_000001;
    localparam logic [95:0] R3 = 96'h000008_000007_000006_000005;
    localparam logic [95:0] R4 = 96'h0F0F0F_0E0E0E_0D0D0D_0C0C0C;
    localparam logic [95:0] R5 = 96'h404040_303030_202020_101010;

    initial begin
        int xfer;
        int src, exp_row, cyc;
        bit fd_seen, hold;
        logic [6143:0] exp_ro;

        //   rst st pv pix        rr   pr rv cr ri rl fd ro
        add(0, 0, 1, 24'h111111, 0,   0, 0, 1, 0, 0, 0, '0);   // 0 reset with pix_valid
        add(0, 0, 1, 24'h111111, 0,   0, 0, 1, 0, 0, 0, '0);
        add(1, 0, 0, 24'h0,      0,   0, 0, 1, 0, 0, 0, '0);   // 2 idle without start
        add(1, 1, 0, 24'h0,      0,   1, 0, 1, 0, 0, 0, '0);   // 3 start
        add(1, 0, 1, 24'h010203, 1,   1, 0, 1, 0, 0, 0, '0);
        add(1, 0, 1, 24'h040506, 1,   1, 0, 1, 0, 0, 0, '0);
        add(1, 0, 1, 24'h070809, 1,   1, 0, 1, 0, 0, 0, '0);
        add(1, 0, 1, 24'h0A0B0C, 1,   1, 1, 1, 0, 0, 0, R0);   // 7 row 0 ready
        add(1, 0, 1, 24'h111111, 0,   1, 1, 1, 0, 0, 0, R0);   // 8 backpressure
        add(1, 1, 1, 24'h222222, 0,   1, 1, 1, 0, 0, 0, R0);   // 9 start ignored
        add(1, 0, 1, 24'h333333, 0,   1, 1, 1, 0, 0, 0, R0);
        add(1, 0, 1, 24'h444444, 0,   0, 1, 1, 0, 0, 0, R0);   // 11 stall
        add(1, 0, 1, 24'h555555, 0,   0, 1, 1, 0, 0, 0, R0);   // 12 pixel refused
        add(1, 0, 1, 24'h555555, 1,   0, 1, 1, 1, 1, 0, R1);   // 13 row 1 loaded
        add(1, 0, 0, 24'h0,      0,   0, 1, 1, 1, 1, 0, R1);   // 14 drain hold
        add(1, 0, 0, 24'h0,      1,   0, 0, 0, 0, 0, 1, '0);   // 15 frame_done
        add(1, 0, 1, 24'h666666, 0,   0, 0, 0, 0, 0, 0, '0);   // 16 idle refuses
        add(1, 1, 0, 24'h0,      0,   1, 0, 0, 0, 0, 0, '0);   // 17 restart
        add(1, 0, 1, 24'hAAAAAA, 0,   1, 0, 0, 0, 0, 0, '0);
        add(1, 0, 1, 24'hBBBBBB, 0,   1, 0, 0, 0, 0, 0, '0);
        add(0, 0, 0, 24'h0,      0,   0, 0, 1, 0, 0, 0, '0);   // 20 reset mid-row
        add(1, 1, 0, 24'h0,      0,   1, 0, 1, 0, 0, 0, '0);
        add(1, 0, 1, 24'h0C0C0C, 1,   1, 0, 1, 0, 0, 0, '0);
        add(1, 0, 1, 24'h0D0D0D, 1,   1, 0, 1, 0, 0, 0, '0);
        add(1, 0, 1, 24'h0E0E0E, 1,   1, 0, 1, 0, 0, 0, '0);
        add(1, 0, 1, 24'h0F0F0F, 1,   1, 1, 1, 0, 0, 0, R4);   // 25 clean row 0
        add(1, 0, 1, 24'h101010, 1,   1, 0, 0, 0, 0, 0, '0);
        add(1, 0, 1, 24'h202020, 1,   1, 0, 0, 0, 0, 0, '0);
        add(1, 0, 1, 24'h303030, 1,   1, 0, 0, 0, 0, 0, '0);
        add(1, 0, 1, 24'h404040, 1,   0, 1, 1, 1, 1, 0, R5);   // 29 last row, drain
        add(1, 0, 0, 24'h0,      1,   0, 0, 0, 0, 0, 1, '0);   // 30 frame_done
        add(1, 0, 1, 24'h777777, 1,   0, 0, 0, 0, 0, 0, '0);   // 31 one-cycle pulse
        add(1, 1, 0, 24'h0,      0,   1, 0, 0, 0, 0, 0, '0);   // 32 start
        add(1, 0, 1, 24'h000001, 0,   1, 0, 0, 0, 0, 0, '0);
        add(1, 0, 1, 24'h000002, 0,   1, 0, 0, 0, 0, 0, '0);
        add(1, 0, 1, 24'h000003, 0,   1, 0, 0, 0, 0, 0, '0);
        add(1, 0, 1, 24'h000004, 0,   1, 1, 1, 0, 0, 0, R2);
        add(1, 0, 1, 24'h000005, 0,   1, 1, 1, 0, 0, 0, R2);
        add(1, 0, 1, 24'h000006, 0,   1, 1, 1, 0, 0, 0, R2);
        add(1, 0, 1, 24'h000007, 0,   1, 1, 1, 0, 0, 0, R2);
        add(1, 0, 1, 24'h000008, 1,   0, 1, 1, 1, 1, 0, R3);   // 40 back-to-back load
        add(1, 0, 0, 24'h0,      1,   0, 0, 0, 0, 0, 1, '0);

        xfer = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            s_rst = tbl[i].rst; s_start = tbl[i].start; s_pv = tbl[i].pv;
            s_pix = tbl[i].pix; s_rr = tbl[i].rr;
            #1;
            if (i >= 22 && i <= 31 && s_rv && s_rr) xfer++;
            @(posedge CLK);
            #1;
            chk("pix_ready", i, 96'(s_pr), 96'(tbl[i].e_pr));
            chk("row_valid", i, 96'(s_rv), 96'(tbl[i].e_rv));
            chk("frame_done", i, 96'(s_fd), 96'(tbl[i].e_fd));
            if (tbl[i].cr) begin
                chk("row_out", i, s_ro, tbl[i].e_ro);
                chk("row_idx", i, 96'(s_ri), 96'(tbl[i].e_ri));
                chk("row_last", i, 96'(s_rl), 96'(tbl[i].e_rl));
            end
        end
        chk("frame_row_xfers", 0, 96'(xfer), 96'd2);
        @(negedge CLK);
        s_start = 0; s_pv = 0; s_rr = 0;

        // Random-stall soak on the default instance
        src = 0; exp_row = 0; cyc = 0; fd_seen = 0; hold = 0;
        @(negedge CLK) d_rst = 0;
        @(negedge CLK);
        @(negedge CLK) begin d_rst = 1; d_start = 1; end
        @(negedge CLK) d_start = 0;
        while (!fd_seen && cyc < 90000) begin
            if (!hold) d_pv = (src < 65536) && ($urandom_range(15) != 0);
            d_pix = gen(src);
            d_rr  = ($urandom_range(1) == 1);
            #1;
            if (d_rv && d_rr) begin
                int bad;
                bad = -1;
                for (int k = 0; k < 256; k++) begin
                    exp_ro[24*k +: 24] = gen(exp_row * 256 + k);
                    if (bad < 0 && d_ro[24*k +: 24] !== exp_ro[24*k +: 24]) bad = k;
                end
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL soak_row[%0d] pixel %0d got %h want %h", exp_row, bad,
                             d_ro[24*bad +: 24], exp_ro[24*bad +: 24]);
                end
                chk("soak_row_idx", exp_row, 96'(d_ri), 96'(exp_row[7:0]));
                chk("soak_row_last", exp_row, 96'(d_rl), 96'(exp_row == 255));
                exp_row++;
            end
            hold = d_pv && !d_pr;
            if (d_pv && d_pr) src++;
            @(posedge CLK);
            #1;
            if (d_fd) fd_seen = 1;
            @(negedge CLK);
            cyc++;
        end
        chk("soak_frame_done", 0, 96'(fd_seen), 96'd1);
        chk("soak_rows", 0, 96'(exp_row), 96'd256);
        chk("soak_pixels", 0, 96'(src), 96'd65536);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
